// File: rtl/conv_window_loader.sv
// Serial-to-parallel loader for one KSIZE x KSIZE convolution window.
// Optional DOUBLE_BUFFER_EN macro adds a second bank so filling overlaps presentation.
module conv_window_loader #(
  parameter int NBITS = 20,
  parameter int KSIZE = 5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NBITS-1:0]                 in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  output logic [KSIZE*KSIZE*NBITS-1:0]     win_data,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [4:0]                       count,
  output logic                             err,
  input  logic                             err_clr
);

  // Handshakes: a word moves on in_valid && in_ready, a window moves on
  // win_valid && win_ready, both at the rising clock edge; once raised, win_valid
  // and win_data hold until the window is taken.
  localparam int N  = KSIZE * KSIZE;
  localparam int WW = N * NBITS;
  localparam logic [4:0] LAST_SLOT = 5'(N - 1);

  logic [4:0] count_q, count_d;
  logic       err_q, err_d;
  logic       in_ready_q, in_ready_d;
  logic       win_valid_q, win_valid_d;

  logic xfer, at_last_slot, complete, early_last, err_set, write_en;
  int   slot_base;

  assign xfer         = in_valid && in_ready_q;
  assign at_last_slot = (count_q == LAST_SLOT);
  assign complete     = xfer && at_last_slot;
  assign early_last   = xfer && in_last && !at_last_slot;
  assign err_set      = early_last || (complete && !in_last);
  assign write_en     = xfer && !early_last;
  assign slot_base    = int'(count_q) * NBITS;

  always_comb begin
    count_d = count_q;
    if (complete || early_last) begin
      count_d = '0;
    end else if (xfer) begin
      count_d = count_q + 5'd1;
    end
  end

  // A new framing error wins over a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

`ifdef DOUBLE_BUFFER_EN

  logic [WW-1:0] bank_q [2];
  logic [WW-1:0] bank_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    occ_q, occ_d;
  logic          consume;

  assign consume = win_valid_q && win_ready;

  // occ counts complete banks; filling and presenting swap banks independently.
  always_comb begin
    bank_d   = bank_q;
    wr_ptr_d = wr_ptr_q ^ complete;
    rd_ptr_d = rd_ptr_q ^ consume;
    occ_d    = occ_q;
    if (write_en) bank_d[wr_ptr_q][slot_base +: NBITS] = in_data;
    if (complete && !consume) begin
      occ_d = occ_q + 2'd1;
    end else if (!complete && consume) begin
      occ_d = occ_q - 2'd1;
    end
    in_ready_d  = (occ_d != 2'd2);
    win_valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q[0]   <= '0;
      bank_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      count_q     <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      count_q     <= count_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign win_data = bank_q[rd_ptr_q];

`else

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] bank_q, bank_d;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    win_valid_d = win_valid_q;
    bank_d      = bank_q;
    if (write_en) bank_d[slot_base +: NBITS] = in_data;
    case (state_q)
      FILL: begin
        in_ready_d  = 1'b1;
        win_valid_d = 1'b0;
        if (complete) begin
          state_d     = HOLD;
          in_ready_d  = 1'b0;
          win_valid_d = 1'b1;
        end
      end
      HOLD: begin
        in_ready_d  = 1'b0;
        win_valid_d = 1'b1;
        if (win_valid_q && win_ready) begin
          state_d     = FILL;
          in_ready_d  = 1'b1;
          win_valid_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      bank_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      count_q     <= count_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign win_data = bank_q;

`endif

  assign in_ready  = in_ready_q;
  assign win_valid = win_valid_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_window_loader.sv
// Bench for conv_window_loader at KSIZE=3, NBITS=20; the zero-bubble test runs
// only when DOUBLE_BUFFER_EN is defined.
module tb_conv_window_loader;

  localparam int NBITS = 20;
  localparam int KSIZE = 3;
  localparam int N     = KSIZE * KSIZE;
  localparam int WW    = N * NBITS;
`ifdef DOUBLE_BUFFER_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NBITS-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_last = 1'b0;
  logic [WW-1:0]    win_data;
  logic             win_valid;
  logic             win_ready = 1'b0;
  logic [4:0]       count;
  logic             err;
  logic             err_clr = 1'b0;

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  conv_window_loader #(.NBITS(NBITS), .KSIZE(KSIZE)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .count(count), .err(err), .err_clr(err_clr)
  );

  // scoreboard state
  int            n_checks = 0;
  int            n_pass = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] tb_win = '0;
  int            tb_count = 0;
  logic          exp_err = 1'b0;

  task automatic check(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [WW-1:0] seq_win(input int base);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[i*NBITS +: NBITS] = NBITS'(base + i);
    return w;
  endfunction

  // Reference behaviour of one accepted word.
  task automatic model_word(input logic [NBITS-1:0] d, input logic last);
    if (tb_count == N - 1) begin
      tb_win[tb_count*NBITS +: NBITS] = d;
      exp_q.push_back(tb_win);
      tb_count = 0;
      if (!last) exp_err = 1'b1;
    end else if (last) begin
      tb_count = 0;
      exp_err = 1'b1;
    end else begin
      tb_win[tb_count*NBITS +: NBITS] = d;
      tb_count++;
    end
  endtask

  // driver tasks
  task automatic send_word(input logic [NBITS-1:0] d, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clock);
    check("count", WW'(count), WW'(tb_count));
    while (!in_ready && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_wait", WW'(in_ready), WW'(1));
      return;
    end
    @(posedge clock);
    #1;
    model_word(d, last);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_seq(input int base, input int n, input logic last_on_end);
    for (int i = 0; i < n; i++) send_word(NBITS'(base + i), last_on_end && (i == n - 1));
    idle();
  endtask

  task automatic take_window();
    int waited;
    waited = 0;
    @(negedge clock);
    while (!win_valid && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    check("win_valid_wait", WW'(win_valid), WW'(1));
    @(posedge clock);
    #1;
    win_ready = 1'b1;
    @(posedge clock);
    #1;
    win_ready = 1'b0;
  endtask

  // scoreboard monitor: pops on every window transfer, checks hold rules
  logic          prev_valid = 1'b0;
  logic          prev_hs = 1'b0;
  logic          prev_reset = 1'b1;
  logic [WW-1:0] prev_data = '0;

  always @(negedge clock) begin
    if (!reset && !prev_reset && prev_valid && !prev_hs) begin
      check("valid_hold", WW'(win_valid), WW'(1));
      check("win_stable", win_data, prev_data);
    end
    if (!reset && win_valid && win_ready) begin
      check("win_expected", WW'(exp_q.size() != 0), WW'(1));
      if (exp_q.size() != 0) check("win_data", win_data, exp_q.pop_front());
    end
    prev_valid = win_valid;
    prev_hs    = win_valid && win_ready;
    prev_reset = reset;
    prev_data  = win_data;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, WW'(in_ready), WW'(0));
    check({tag, "_win_valid"}, WW'(win_valid), WW'(0));
    check({tag, "_win_data"}, win_data, WW'(0));
    check({tag, "_count"}, WW'(count), WW'(0));
    check({tag, "_err"}, WW'(err), WW'(0));
  endtask

  logic done5;
  int   vtimes[$];

  initial begin
    // reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rdy_after_rst", WW'(in_ready), WW'(1));
    @(posedge clock);
    #1;

    // 1: one clean window, held
    send_seq(1, N, 1'b1);
    @(negedge clock);
    check("t1_win_valid", WW'(win_valid), WW'(1));
    check("t1_data", win_data, seq_win(1));
    check("t1_in_ready", WW'(in_ready), WW'(DB));
    check("t1_err", WW'(err), WW'(0));
    repeat (3) @(posedge clock);
    #1;

    // 2: consume, then a second window
    win_ready = 1'b1;
    @(posedge clock);
    #1;
    win_ready = 1'b0;
    @(negedge clock);
    check("t2_win_valid", WW'(win_valid), WW'(0));
    check("t2_in_ready", WW'(in_ready), WW'(1));
    check("t2_count", WW'(count), WW'(0));
    @(posedge clock);
    #1;
    send_seq(10, N, 1'b1);
    take_window();

    // 3: early last, recovery, clear, missing last
    send_seq(5, 4, 1'b1);
    @(negedge clock);
    check("t3_err", WW'(err), WW'(1));
    check("t3_count", WW'(count), WW'(0));
    check("t3_no_win", WW'(win_valid), WW'(0));
    @(posedge clock);
    #1;
    send_seq(31, N, 1'b1);
    take_window();
    @(negedge clock);
    check("t3_err_sticky", WW'(err), WW'(exp_err));
    @(posedge clock);
    #1;
    err_clr = 1'b1;
    exp_err = 1'b0;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    @(negedge clock);
    check("t3_err_clr", WW'(err), WW'(0));
    @(posedge clock);
    #1;
    send_seq(51, N, 1'b0);
    take_window();
    @(negedge clock);
    check("t3_no_last_err", WW'(err), WW'(exp_err));
    @(posedge clock);
    #1;
    err_clr = 1'b1;
    exp_err = 1'b0;
    @(posedge clock);
    #1;
    err_clr = 1'b0;

    // 4: reset mid-window discards the partial words
    send_seq(200, 5, 1'b0);
    reset = 1'b1;
    tb_count = 0;
    exp_err = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("t4_rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    send_seq(32'h100, N, 1'b1);
    take_window();

    // 5: continuous input, random consumer stalls, four windows
    done5 = 1'b0;
    fork
      begin
        for (int w = 0; w < 4; w++)
          for (int i = 0; i < N; i++)
            send_word(NBITS'($urandom_range(0, (1 << NBITS) - 1)), i == N - 1);
        idle();
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          @(posedge clock);
          #1;
          win_ready = ($urandom_range(0, 99) >= 30);
        end
        win_ready = 1'b1;
      end
    join
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clock);
    check("t5_drained", WW'(exp_q.size()), WW'(0));
    @(posedge clock);
    #1;

`ifdef DOUBLE_BUFFER_EN
    // 6: zero-bubble streaming with an always-ready core
    win_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3 * N; i++) send_word(NBITS'(700 + i), (i % N) == N - 1);
        idle();
      end
      begin
        for (int k = 0; k < 3 * N + 6; k++) begin
          @(negedge clock);
          check("t6_in_ready", WW'(in_ready), WW'(1));
          if (win_valid) vtimes.push_back(cyc);
        end
      end
    join
    check("t6_windows", WW'(vtimes.size()), WW'(3));
    for (int i = 1; i < vtimes.size(); i++)
      check("t6_spacing", WW'(vtimes[i] - vtimes[i-1]), WW'(N));
`endif

    win_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clock);
    check("final_queue_empty", WW'(exp_q.size()), WW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
